// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, blocking instruction cache.
//
// Hits return the instruction combinationally in the cycle the fetch address
// is presented. A miss stalls the fetch stage and refills the whole line,
// word 0 first, through a one-outstanding valid/ready read channel.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   cpu_req_valid/addr    fetch request (addr[1:0] ignored)
//   cpu_resp_valid/data   hit indication and instruction (bubble on no hit)
//   cmiss_stall           stall to control/datapath while a miss is serviced
//   flush                 single-cycle invalidate-all (fence.i)
//   mem_req_valid/ready   backing-memory read request handshake
//   mem_req_addr          word-aligned read address
//   mem_resp_valid/data   backing-memory read data
//   hit_count/miss_count  free-running event counters (wrap mod 2^32)
module icache_direct #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req_valid,
  input  logic [31:0] cpu_req_addr,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_resp_data,
  output logic        cmiss_stall,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int DATA_W = 32;
  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int OB     = 2 + OFF_W;
  localparam int TAG_W  = 32 - OB - IDX_W;
  localparam logic [DATA_W-1:0] BUBBLE    = 32'h0000_4033;
  localparam logic [OFF_W-1:0]  LAST_WORD = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e             state_q, state_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   fill_idx_q, fill_idx_d;
  logic [TAG_W-1:0]   fill_tag_q, fill_tag_d;
  logic               flush_pend_q, flush_pend_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [31:0]        hit_count_q, hit_count_d;
  logic [31:0]        miss_count_q, miss_count_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [DATA_W-1:0]  data_q [LINES][WORDS];

  logic [OFF_W-1:0]   req_off;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic               word_wr;
  logic               tag_wr;
  logic               unused_addr_bits;

  assign req_off = cpu_req_addr[OB-1:2];
  assign req_idx = cpu_req_addr[OB+IDX_W-1:OB];
  assign req_tag = cpu_req_addr[31:OB+IDX_W];
  assign unused_addr_bits = ^cpu_req_addr[1:0];

  // Lookup is only meaningful in IDLE; during a refill the fetch is stalled.
  assign hit = cpu_req_valid && (state_q == IDLE) && valid_q[req_idx] &&
               (tag_q[req_idx] == req_tag);

  assign cpu_resp_valid = hit;
  assign cpu_resp_data  = hit ? data_q[req_idx][req_off] : BUBBLE;
  assign cmiss_stall    = ((state_q == IDLE) && cpu_req_valid && !hit) ||
                          (state_q != IDLE);
  assign mem_req_addr   = {fill_tag_q, fill_idx_q, cnt_q, 2'b00};
  assign hit_count      = hit_count_q;
  assign miss_count     = miss_count_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fill_idx_d    = fill_idx_q;
    fill_tag_d    = fill_tag_q;
    flush_pend_d  = flush_pend_q;
    valid_d       = valid_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    mem_req_valid = 1'b0;
    word_wr       = 1'b0;
    tag_wr        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          if (hit) begin
            hit_count_d = hit_count_q + 32'd1;
          end else begin
            // The line is invalid while it is partially overwritten.
            fill_idx_d       = req_idx;
            fill_tag_d       = req_tag;
            cnt_d            = '0;
            valid_d[req_idx] = 1'b0;
            miss_count_d     = miss_count_q + 32'd1;
            state_d          = REQ;
          end
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          word_wr = 1'b1;
          if (cnt_q == LAST_WORD) begin
            tag_wr              = 1'b1;
            valid_d[fill_idx_q] = !flush_pend_q;
            flush_pend_d        = 1'b0;
            state_d             = IDLE;
          end else begin
            cnt_d   = cnt_q + OFF_W'(1);
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A flush arriving mid-refill must also keep the in-flight line from
    // being marked valid; a flush in IDLE (even alongside a miss) does not,
    // because that refill fetches post-flush memory contents.
    if (flush) begin
      valid_d = '0;
      if ((state_q != IDLE) && (state_d != IDLE)) flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Storage arrays and the latched fill address carry no reset.
  always_ff @(posedge clk) begin
    fill_idx_q <= fill_idx_d;
    fill_tag_q <= fill_tag_d;
    if (word_wr) data_q[fill_idx_q][cnt_q] <= mem_resp_data;
    if (tag_wr)  tag_q[fill_idx_q] <= fill_tag_q;
  end

endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req_valid;
  logic [31:0] cpu_req_addr;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_data;
  logic        cmiss_stall;
  logic        flush = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'h0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] data_exp_q[$];
  logic [31:0] addr_exp_q[$];

  // memory model state
  logic        resp_due = 1'b0;
  logic [31:0] resp_addr = 32'h0;
  int          flush_req = 0, flush_ack = 0;
  int          bp_req = 0, bp_ack = 0;
  int          bp_skip = 0, bp_left = 0;
  logic        wflush_req = 1'b0, wflush_done = 1'b0;
  localparam logic [31:0] WF_ADDR = 32'h34;

  icache_direct #(.LINES(16), .WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
    .cmiss_stall(cmiss_stall), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the cache reports a hit.
  always @(negedge clk) begin
    if (cpu_resp_valid) begin
      if (data_exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL resp_unexpected: got 0x%08h, required no response", cpu_resp_data);
      end else begin
        check("resp_data", cpu_resp_data, data_exp_q.pop_front());
      end
    end
  end

  // Backing memory: 1-cycle response latency, optional backpressure and a
  // flush injected in the WAIT cycle of a chosen word.
  always @(negedge clk) begin
    if (reset) resp_due = 1'b0;
    flush = 1'b0;
    if (flush_req != flush_ack) begin flush = 1'b1; flush_ack = flush_req; end
    if (resp_due && wflush_req && !wflush_done && resp_addr == WF_ADDR) begin
      flush = 1'b1; wflush_done = 1'b1;
    end
    mem_resp_valid = resp_due;
    mem_resp_data  = memword(resp_addr);
    resp_due = 1'b0;
    if (bp_req != bp_ack) begin bp_skip = 2; bp_left = 5; bp_ack = bp_req; end
    mem_req_ready = 1'b1;
    if (mem_req_valid) begin
      if (bp_skip == 0 && bp_left > 0) begin
        mem_req_ready = 1'b0;
        bp_left--;
        check("bp_addr_stable", mem_req_addr, 32'h8);
      end else begin
        if (bp_skip > 0) bp_skip--;
        resp_due  = 1'b1;
        resp_addr = mem_req_addr;
        if (addr_exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL mem_req_unexpected: got 0x%08h, required no request", mem_req_addr);
        end else begin
          check("mem_req_addr", mem_req_addr, addr_exp_q.pop_front());
        end
      end
    end
  end

  task automatic push_fill(input logic [31:0] base, input int words);
    for (int k = 0; k < words; k++) addr_exp_q.push_back(base + 32'(4 * k));
  endtask

  // Holds a fetch until the cache answers; counts stalled cycles.
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input int fills,
                       input int exp_stall, input string nm);
    int st;
    bit got;
    for (int f = 0; f < fills; f++) push_fill({a[31:4], 4'h0}, 4);
    data_exp_q.push_back(exp);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    st = 0; got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (cpu_resp_valid) got = 1'b1;
      else if (cmiss_stall) st++;
      @(posedge clk); #1;
    end
    cpu_req_valid = 1'b0;
    check({nm, "_answered"}, 32'(got), 32'd1);
    check({nm, "_stall_cycles"}, 32'(st), 32'(exp_stall));
  endtask

  task automatic flush_pulse();
    flush_req++;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h0;
    bit found;
    reset = 1'b1; cpu_req_valid = 1'b0; cpu_req_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_cpu_resp_valid", 32'(cpu_resp_valid), 32'd0);
    check("rst_cmiss_stall", 32'(cmiss_stall), 32'd0);
    check("rst_resp_bubble", cpu_resp_data, 32'h4033);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    @(posedge clk); #1;

    // cold miss
    fetch(32'h0, 32'h1000, 1, 9, "cold");
    check("cold_miss_count", miss_count, 32'd1);

    // hit sweep
    h0 = int'(hit_count);
    fetch(32'h4, 32'h1001, 0, 0, "hit4");
    fetch(32'h8, 32'h1002, 0, 0, "hit8");
    fetch(32'hC, 32'h1003, 0, 0, "hitC");
    check("sweep_hit_delta", hit_count - 32'(h0), 32'd3);

    // conflict on index 0
    fetch(32'h100, 32'h1040, 1, 9, "conf100");
    fetch(32'h0, 32'h1000, 1, 9, "conf0");
    check("conf_miss_count", miss_count, 32'd3);

    // flush in IDLE, then a miss with 5 cycles of backpressure on word 2
    flush_pulse();
    bp_req++;
    fetch(32'h0, 32'h1000, 1, 14, "bp");
    check("bp_miss_count", miss_count, 32'd4);
    fetch(32'h8, 32'h1002, 0, 0, "bp_word2");

    // flush during WAIT of word 1: first fill not kept, second fill follows
    wflush_req = 1'b1;
    fetch(32'h30, 32'h100C, 2, 18, "wflush");
    check("wflush_miss_count", miss_count, 32'd6);
    fetch(32'h34, 32'h100D, 0, 0, "wflush_hit");

    // reset while requesting word 2
    flush_pulse();
    push_fill(32'h0, 3);
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_addr == 32'h8) found = 1'b1;
    end
    check("rst_mid_reached_word2", 32'(found), 32'd1);
    reset = 1'b1; cpu_req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mid_cmiss_stall", 32'(cmiss_stall), 32'd0);
    check("rst_mid_miss_count", miss_count, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    fetch(32'h0, 32'h1000, 1, 9, "after_rst");
    check("after_rst_miss_count", miss_count, 32'd1);

    repeat (4) @(posedge clk);
    check("addr_queue_drained", 32'(addr_exp_q.size()), 32'd0);
    check("data_queue_drained", 32'(data_exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
